// File: rtl/bg_tile_fetcher_pkg.sv
// rtl/bg_tile_fetcher_pkg.sv - shared states, geometry constants and VRAM address helpers for bg_tile_fetcher
package bg_tile_fetcher_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_MAP_RD  = 3'd1;
    localparam logic [2:0] ST_IDX_CAP = 3'd2;
    localparam logic [2:0] ST_DATA_RD = 3'd3;
    localparam logic [2:0] ST_ROW_CAP = 3'd4;
    localparam logic [2:0] ST_SHIFT   = 3'd5;

    localparam int TILES_PER_LINE = 20;
    localparam int MAP_W          = 32;
    localparam int BYTES_PER_TILE = 16;
    localparam int PIX_PER_TILE   = 8;

    localparam logic [15:0] MAP_BASE         = 16'h1800;
    localparam logic [15:0] TILE_BASE        = 16'h0000;
    localparam logic [15:0] SIGNED_TILE_BASE = 16'h1000;

    // Tile-map byte for a map row (row[7:3]) and column; wraps modulo 2^16.
    function automatic logic [15:0] map_addr(input logic [4:0] map_row, input logic [4:0] col);
        return MAP_BASE + 16'(map_row) * 16'(MAP_W) + 16'(col);
    endfunction

    // First bitplane byte of a tile row, unsigned index mode.
    function automatic logic [15:0] tile_addr(input logic [7:0] idx, input logic [2:0] fine);
        return TILE_BASE + 16'(idx) * 16'(BYTES_PER_TILE) + 16'({fine, 1'b0});
    endfunction

    // First bitplane byte of a tile row, signed index mode centred on 0x1000.
    function automatic logic [15:0] tile_addr_signed(input logic [7:0] idx, input logic [2:0] fine);
        return SIGNED_TILE_BASE + {{8{idx[7]}}, idx} * 16'(BYTES_PER_TILE) + 16'({fine, 1'b0});
    endfunction

endpackage

// File: rtl/bg_tile_fetcher_tile_row_shifter.sv
// rtl/bg_tile_fetcher_tile_row_shifter.sv - holds one tile row's bitplanes and streams 8 pixels MSB first
module tile_row_shifter
    import bg_tile_fetcher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] lo_i,
    input  logic [7:0] hi_i,
    input  logic       ready_i,
    output logic [1:0] pix_o,
    output logic       valid_o,
    output logic       last_o
);

    logic [7:0] lo_q, lo_d;
    logic [7:0] hi_q, hi_d;
    logic [2:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       accept;

    assign accept  = valid_q & ready_i;
    assign pix_o   = {hi_q[7], lo_q[7]};
    assign valid_o = valid_q;
    assign last_o  = accept && (cnt_q == 3'(PIX_PER_TILE - 1));

    // Load a fresh row, or shift one pixel out per accepted transfer; hold under backpressure.
    always_comb begin
        lo_d    = lo_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            lo_d    = lo_i;
            hi_d    = hi_i;
            cnt_d   = 3'd0;
            valid_d = 1'b1;
        end else if (accept) begin
            lo_d  = {lo_q[6:0], 1'b0};
            hi_d  = {hi_q[6:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(PIX_PER_TILE - 1)) begin
                valid_d = 1'b0;
            end
        end
    end

    // Shifter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/bg_tile_fetcher.sv
// rtl/bg_tile_fetcher.sv - background tile fetcher top; SIGNED_TILE_IDX_EN adds signed tile indexing
module bg_tile_fetcher
    import bg_tile_fetcher_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  row,
    input  logic [4:0]  col0,
`ifdef SIGNED_TILE_IDX_EN
    input  logic        idx_signed,
`endif
    output logic [15:0] vram_addr,
    input  logic [7:0]  vram_d0,
    input  logic [7:0]  vram_d1,
    output logic [1:0]  pix,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        busy,
    output logic        line_done
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  row_q, row_d;
    logic [4:0]  col_q, col_d;
    logic [4:0]  tcnt_q, tcnt_d;
    logic [15:0] addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load;
    logic        last_pix;
    logic [15:0] row_addr;
`ifdef SIGNED_TILE_IDX_EN
    logic        sgn_q, sgn_d;
`endif

    assign vram_addr = addr_q;
    assign busy      = busy_q;
    assign line_done = done_q;

    // Tile-row address for the index byte VRAM is presenting now.
`ifdef SIGNED_TILE_IDX_EN
    assign row_addr = sgn_q ? tile_addr_signed(vram_d0, row_q[2:0]) : tile_addr(vram_d0, row_q[2:0]);
`else
    assign row_addr = tile_addr(vram_d0, row_q[2:0]);
`endif

    // Fetch sequencer: map read, index capture, row read, row capture, then wait out 8 pixels.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tcnt_d  = tcnt_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;
`ifdef SIGNED_TILE_IDX_EN
        sgn_d   = sgn_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    row_d   = row;
                    col_d   = col0;
                    tcnt_d  = 5'd0;
                    addr_d  = map_addr(row[7:3], col0);
                    busy_d  = 1'b1;
`ifdef SIGNED_TILE_IDX_EN
                    sgn_d   = idx_signed;
`endif
                    state_d = ST_MAP_RD;
                end
            end
            ST_MAP_RD:  state_d = ST_IDX_CAP;
            ST_IDX_CAP: begin
                addr_d  = row_addr;
                state_d = ST_DATA_RD;
            end
            ST_DATA_RD: state_d = ST_ROW_CAP;
            ST_ROW_CAP: begin
                load    = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_pix) begin
                    col_d = col_q + 5'd1;
                    if (tcnt_q == 5'(TILES_PER_LINE - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d  = tcnt_q + 5'd1;
                        addr_d  = map_addr(row_q[7:3], col_q + 5'd1);
                        state_d = ST_MAP_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= 8'd0;
            col_q   <= 5'd0;
            tcnt_q  <= 5'd0;
            addr_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SIGNED_TILE_IDX_EN
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tcnt_q  <= tcnt_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SIGNED_TILE_IDX_EN
            sgn_q   <= sgn_d;
`endif
        end
    end

    tile_row_shifter u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .lo_i    (vram_d0),
        .hi_i    (vram_d1),
        .ready_i (pix_ready),
        .pix_o   (pix),
        .valid_o (pix_valid),
        .last_o  (last_pix)
    );

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// tb/tb_bg_tile_fetcher.sv - self-checking bench for bg_tile_fetcher against a line-level pixel model
module tb_bg_tile_fetcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  row = 8'd0;
    logic [4:0]  col0 = 5'd0;
    logic [15:0] vram_addr;
    logic [7:0]  vram_d0 = 8'd0;
    logic [7:0]  vram_d1 = 8'd0;
    logic [1:0]  pix;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        busy;
    logic        line_done;
`ifdef SIGNED_TILE_IDX_EN
    logic        idx_signed = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  mem [0:65535];
    logic [15:0] addr_p1;
    logic [1:0]  got_q[$];
    logic [1:0]  exp_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          hold_err = 0;
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [1:0]  prev_pix = 2'd0;

    bg_tile_fetcher dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .row       (row),
        .col0      (col0),
`ifdef SIGNED_TILE_IDX_EN
        .idx_signed(idx_signed),
`endif
        .vram_addr (vram_addr),
        .vram_d0   (vram_d0),
        .vram_d1   (vram_d1),
        .pix       (pix),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .busy      (busy),
        .line_done (line_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // VRAM read port: one edge of latency, adjacent byte pair.
    assign addr_p1 = vram_addr + 16'd1;
    always @(posedge clk) begin
        vram_d0 <= mem[vram_addr];
        vram_d1 <= mem[addr_p1];
    end

    // Stream monitor: records accepted pixels, line_done pulses and backpressure hold violations.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && !prev_ready && (pix_valid !== 1'b1 || pix !== prev_pix)) hold_err++;
            if (pix_valid && pix_ready) got_q.push_back(pix);
            if (line_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_valid = pix_valid;
            prev_ready = pix_ready;
            prev_pix   = pix;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected 160 pixels of a line, straight from the tile-map/tile-data layout.
    task automatic build_model(input int r, input int c0, input bit sgn);
        int c, ma, idx, sidx, ta;
        logic [7:0] lo, hi;
        exp_q.delete();
        for (int t = 0; t < 20; t++) begin
            c   = (c0 + t) % 32;
            ma  = 'h1800 + (r / 8) * 32 + c;
            idx = int'(mem[ma]);
            sidx = (sgn && idx >= 128) ? idx - 256 : idx;
            ta  = sgn ? ('h1000 + sidx * 16 + (r % 8) * 2) & 'hFFFF : (idx * 16 + (r % 8) * 2) & 'hFFFF;
            lo  = mem[ta];
            hi  = mem[(ta + 1) & 'hFFFF];
            for (int b = 7; b >= 0; b--) exp_q.push_back({hi[b], lo[b]});
        end
    endtask

    // Pulse start with the given line parameters; t0 is the cycle count just after the start edge.
    task automatic begin_line(input logic [7:0] r, input logic [4:0] c0, input bit sgn, output int t0);
        build_model(int'(r), int'(c0), sgn);
        got_q.delete();
        done_cnt = 0;
        hold_err = 0;
        row  = r;
        col0 = c0;
`ifdef SIGNED_TILE_IDX_EN
        idx_signed = sgn;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (vram_addr !== 16'd0) begin failures++; $display("FAIL reset_vram_addr got=%h want=0000", vram_addr); end
        checks++; if (pix !== 2'd0) begin failures++; $display("FAIL reset_pix got=%0d want=0", pix); end
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%b want=0", pix_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (line_done !== 1'b0) begin failures++; $display("FAIL reset_line_done got=%b want=0", line_done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_first_tile();
        int t0, n, bad;
        logic [1:0] seq [8];
        seq = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
        mem[16'h183F] = 8'h05;
        mem[16'h0056] = 8'hF0;
        mem[16'h0057] = 8'hCC;
        pix_ready = 1'b1;
        begin_line(8'h0B, 5'h1F, 1'b0, t0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b want=1", busy); end
        checks++; if (vram_addr !== 16'h183F) begin failures++; $display("FAIL first_map_addr got=%h want=183f", vram_addr); end
        step(); step();
        checks++; if (vram_addr !== 16'h0056) begin failures++; $display("FAIL first_tile_addr got=%h want=0056", vram_addr); end
        step(); step();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (pix_valid !== 1'b1 || pix !== seq[i]) begin
                failures++;
                $display("FAIL first_pix%0d got=%0d/v%b want=%0d/v1", i, pix, pix_valid, seq[i]);
            end
            step();
        end
        checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL first_valid_end got=%b want=0", pix_valid); end
        checks++; if (vram_addr !== 16'h1820) begin failures++; $display("FAIL first_wrap_addr got=%h want=1820", vram_addr); end
        row = 8'h55; col0 = 5'd3; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (done_cnt == 0 && n < 400) begin step(); n++; end
        checks++; if (done_cnt == 0) begin failures++; $display("FAIL full_done_timeout got=none want=pulse"); end
        checks++; if (done_cyc !== t0 + 240) begin failures++; $display("FAIL full_done_time got=%0d want=%0d", done_cyc - t0, 240); end
        repeat (3) step();
        checks++; if (done_cnt !== 1 || line_done !== 1'b0) begin failures++; $display("FAIL full_done_pulses got=%0d want=1", done_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL full_busy_after got=%b want=0", busy); end
        checks++; if (got_q.size() != 160) begin failures++; $display("FAIL full_count got=%0d want=160", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 160; i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL full_pixels got=%0d_wrong want=0_wrong", bad); end
    endtask

    task automatic test_backpressure();
        int t0, n, bad;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        begin_line(8'($urandom), 5'($urandom), 1'b0, t0);
        n = 0;
        while (done_cnt == 0 && n < 3000) begin
            pix_ready = pat[n % 4];
            step();
            n++;
        end
        pix_ready = 1'b1;
        step();
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cnt); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold got=%0d_violations want=0", hold_err); end
        checks++; if (got_q.size() != 160) begin failures++; $display("FAIL bp_count got=%0d want=160", got_q.size()); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 160; i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL bp_pixels got=%0d_wrong want=0_wrong", bad); end
    endtask

    task automatic test_reset_mid();
        int t0, n, bad, want_addr;
        logic [7:0] r;
        logic [4:0] c0;
        pix_ready = 1'b1;
        begin_line(8'($urandom), 5'($urandom), 1'b0, t0);
        repeat (91) step();
        checks++; if (pix_valid !== 1'b1 || got_q.size() != 59) begin failures++; $display("FAIL mid_progress got=%0d/v%b want=59/v1", got_q.size(), pix_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vram_addr !== 16'd0 || pix !== 2'd0 || pix_valid !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%h/%0d/%b/%b/%b want=0000/0/0/0/0", vram_addr, pix, pix_valid, busy, line_done);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        r  = 8'($urandom);
        c0 = 5'($urandom);
        want_addr = ('h1800 + (int'(r) / 8) * 32 + int'(c0)) & 'hFFFF;
        begin_line(r, c0, 1'b0, t0);
        checks++; if (vram_addr !== 16'(want_addr)) begin failures++; $display("FAIL mid_restart_addr got=%h want=%h", vram_addr, 16'(want_addr)); end
        n = 0;
        while (done_cnt == 0 && n < 400) begin step(); n++; end
        checks++; if (done_cnt != 1 || done_cyc !== t0 + 240) begin failures++; $display("FAIL mid_restart_done got=%0d want=240", done_cyc - t0); end
        bad = 0;
        for (int i = 0; i < got_q.size() && i < 160; i++) if (got_q[i] !== exp_q[i]) bad++;
        checks++; if (bad != 0 || got_q.size() != 160) begin failures++; $display("FAIL mid_restart_pixels got=%0d_wrong/%0d want=0_wrong/160", bad, got_q.size()); end
    endtask

    task automatic test_random_lines();
        int t0, n, bad;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 'h2000; a++) mem[a] = 8'($urandom);
            begin_line(8'($urandom), 5'($urandom), 1'b0, t0);
            n = 0;
            while (done_cnt == 0 && n < 3000) begin
                pix_ready = ($urandom % 4) != 0;
                step();
                n++;
            end
            pix_ready = 1'b1;
            step();
            bad = 0;
            for (int i = 0; i < got_q.size() && i < 160; i++) if (got_q[i] !== exp_q[i]) bad++;
            checks++;
            if (done_cnt != 1 || hold_err != 0 || bad != 0 || got_q.size() != 160) begin
                failures++;
                $display("FAIL rand_line%0d got=done%0d/hold%0d/wrong%0d/n%0d want=done1/hold0/wrong0/n160", k, done_cnt, hold_err, bad, got_q.size());
            end
        end
    endtask

`ifdef SIGNED_TILE_IDX_EN
    task automatic test_signed();
        int t0, n, bad, ma;
        logic [7:0] r;
        logic [4:0] c0;
        logic [7:0] idxs [2];
        logic [15:0] want [2];
        idxs = '{8'h80, 8'h7F};
        want = '{16'h0800, 16'h17F0};
        pix_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            r  = {5'($urandom), 3'd0};
            c0 = 5'($urandom);
            ma = 'h1800 + (int'(r) / 8) * 32 + int'(c0);
            mem[ma] = idxs[k];
            begin_line(r, c0, 1'b1, t0);
            step(); step();
            checks++; if (vram_addr !== want[k]) begin failures++; $display("FAIL signed_addr%0d got=%h want=%h", k, vram_addr, want[k]); end
            n = 0;
            while (done_cnt == 0 && n < 400) begin step(); n++; end
            bad = 0;
            for (int i = 0; i < got_q.size() && i < 160; i++) if (got_q[i] !== exp_q[i]) bad++;
            checks++; if (bad != 0 || got_q.size() != 160) begin failures++; $display("FAIL signed_pixels%0d got=%0d_wrong/%0d want=0_wrong/160", k, bad, got_q.size()); end
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        test_reset();
        test_first_tile();
        test_backpressure();
        test_reset_mid();
        test_random_lines();
`ifdef SIGNED_TILE_IDX_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
